// File: rtl/spi_slv.sv
// SPI mode-0 target running on the system clock: oversamples SCLK/MOSI/SS_N,
// shifts a preloaded word out on MISO and delivers each received frame in parallel.
`timescale 1ns/1ps

module spi_slv #(
    parameter int SPI_MAXLEN  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          sreset,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    input  logic [SPI_MAXLEN-1:0]         tx_data,
    output logic                          rx_valid,
    output logic [SPI_MAXLEN-1:0]         rx_data,
    output logic [$clog2(SPI_MAXLEN):0]   rx_nbits,
    output logic                          rx_overrun,
    output logic                          busy,
    input  logic                          SCLK,
    input  logic                          MOSI,
    input  logic                          SS_N,
    output logic                          MISO,
    output logic                          MISO_OE
);

    localparam int CNTW = $clog2(SPI_MAXLEN) + 1;
    localparam int SETW = $clog2(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        ST_RESYNC,
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;

    logic [SYNC_STAGES-1:0]  r_sclk_sync;
    logic [SYNC_STAGES-1:0]  r_mosi_sync;
    logic [SYNC_STAGES-1:0]  r_ss_sync;
    logic                    r_sclk_d;
    logic                    r_ss_d;
    logic [SETW-1:0]         r_settle;

    logic [SPI_MAXLEN-1:0]   r_tx_shift;
    logic [SPI_MAXLEN-1:0]   r_rx_shift;
    logic [CNTW-1:0]         r_bit_cnt;
    logic                    r_ovf;
    logic                    r_pend_valid;
    logic [SPI_MAXLEN-1:0]   r_pend_data;
    logic                    r_miso;
    logic                    r_rx_valid;
    logic [SPI_MAXLEN-1:0]   r_rx_data;
    logic [CNTW-1:0]         r_rx_nbits;
    logic                    r_rx_overrun;

    logic                    w_sclk;
    logic                    w_mosi;
    logic                    w_ss;
    logic                    w_sclk_rise;
    logic                    w_sclk_fall;
    logic                    w_ss_rise;
    logic                    w_ss_fall;
    logic                    w_settled;
    logic                    w_hs;
    logic                    w_start;
    logic                    w_end;
    logic [SPI_MAXLEN-1:0]   w_load_word;
    logic [SPI_MAXLEN-1:0]   w_rx_mask;

    // Input synchronizers; the extra registered copy of the last stage gives edge detection.
    always_ff @(posedge clk) begin
        if (sreset) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_ss_sync   <= '1;
            r_sclk_d    <= 1'b0;
            r_ss_d      <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let each stage take the previous stage's old value.
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], SS_N};
            r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
            r_ss_d      <= r_ss_sync[SYNC_STAGES-1];
        end
    end

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_ss        = r_ss_sync[SYNC_STAGES-1];
    assign w_sclk_rise =  w_sclk & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk &  r_sclk_d;
    assign w_ss_rise   =  w_ss   & ~r_ss_d;
    assign w_ss_fall   = ~w_ss   &  r_ss_d;

    // The chains reset to idle levels, so RESYNC must wait until they have
    // flushed before trusting SS_N; otherwise a select held low across reset
    // would look like a fresh frame.
    assign w_settled = (r_settle == SETW'(SYNC_STAGES));

    always_ff @(posedge clk) begin
        if (sreset) begin
            r_settle <= '0;
        end else if (!w_settled) begin
            r_settle <= r_settle + SETW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (sreset) begin
            r_state <= ST_RESYNC;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        w_state_next = r_state;
        w_start      = 1'b0;
        w_end        = 1'b0;
        case (r_state)
            ST_RESYNC: begin
                if (w_settled && w_ss) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (w_ss_fall) begin
                    w_state_next = ST_ACTIVE;
                    w_start      = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (w_ss_rise) begin
                    w_state_next = ST_IDLE;
                    w_end        = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_RESYNC;
            end
        endcase
    end

    assign tx_ready = ~r_pend_valid;
    assign w_hs     = tx_valid & ~r_pend_valid;

    // A handshake coinciding with frame start bypasses the pending register.
    assign w_load_word = r_pend_valid ? r_pend_data :
                         w_hs         ? tx_data     : '0;

    always_comb begin
        w_rx_mask = '0;
        for (int i = 0; i < SPI_MAXLEN; i++) begin
            w_rx_mask[i] = (CNTW'(i) < r_bit_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (sreset) begin
            r_tx_shift   <= '0;
            r_rx_shift   <= '0;
            r_bit_cnt    <= '0;
            r_ovf        <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_data  <= '0;
            r_miso       <= 1'b0;
            r_rx_valid   <= 1'b0;
            r_rx_data    <= '0;
            r_rx_nbits   <= '0;
            r_rx_overrun <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_start) begin
                r_tx_shift   <= w_load_word;
                r_miso       <= w_load_word[SPI_MAXLEN-1];
                r_bit_cnt    <= '0;
                r_ovf        <= 1'b0;
                r_pend_valid <= 1'b0;
            end else begin
                if (w_hs) begin
                    r_pend_valid <= 1'b1;
                    r_pend_data  <= tx_data;
                end
                // SS_N rise wins over any SCLK edge seen in the same cycle.
                if (w_end) begin
                    r_miso <= 1'b0;
                    if (r_bit_cnt != '0) begin
                        r_rx_valid   <= 1'b1;
                        r_rx_data    <= r_rx_shift & w_rx_mask;
                        r_rx_nbits   <= r_bit_cnt;
                        r_rx_overrun <= r_ovf;
                    end
                end else if (r_state == ST_ACTIVE) begin
                    if (w_sclk_rise) begin
                        if (r_bit_cnt == CNTW'(SPI_MAXLEN)) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_rx_shift <= {r_rx_shift[SPI_MAXLEN-2:0], w_mosi};
                            r_bit_cnt  <= r_bit_cnt + CNTW'(1);
                        end
                    end else if (w_sclk_fall) begin
                        r_tx_shift <= {r_tx_shift[SPI_MAXLEN-2:0], 1'b0};
                        r_miso     <= r_tx_shift[SPI_MAXLEN-2];
                    end
                end
            end
        end
    end

    assign busy       = (r_state == ST_ACTIVE);
    assign MISO_OE    = busy;
    assign MISO       = r_miso;
    assign rx_valid   = r_rx_valid;
    assign rx_data    = r_rx_data;
    assign rx_nbits   = r_rx_nbits;
    assign rx_overrun = r_rx_overrun;

endmodule

// File: tb/tb_spi_slv.sv
// Directed bench for spi_slv: a bit-level SPI master plus a frame-level model
// of the expected MISO stream and received words.
`timescale 1ns/1ps

module tb_spi_slv;

    localparam int N = 16;
    localparam int H = 8;   // SCLK half period in clk cycles

    logic          clk;
    logic          sreset;
    logic          tx_valid;
    logic          tx_ready;
    logic [N-1:0]  tx_data;
    logic          rx_valid;
    logic [N-1:0]  rx_data;
    logic [4:0]    rx_nbits;
    logic          rx_overrun;
    logic          busy;
    logic          SCLK;
    logic          MOSI;
    logic          SS_N;
    logic          MISO;
    logic          MISO_OE;

    typedef struct {
        logic [15:0] data;
        int          nbits;
        logic        ovf;
    } rx_t;

    int            n_tests = 0;
    int            n_fail  = 0;
    rx_t           exp_rx_q[$];
    logic [15:0]   exp_tx_q[$];
    rx_t           e_rx;
    int            rx_count = 0;
    logic [15:0]   last_rx_data  = '0;
    int            last_rx_nbits = 0;
    logic          last_rx_ovf   = 1'b0;
    logic          prev_rx_valid = 1'b0;
    logic [31:0]   got;
    int            cnt_snap;

    spi_slv #(.SPI_MAXLEN(N), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .sreset     (sreset),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_nbits   (rx_nbits),
        .rx_overrun (rx_overrun),
        .busy       (busy),
        .SCLK       (SCLK),
        .MOSI       (MOSI),
        .SS_N       (SS_N),
        .MISO       (MISO),
        .MISO_OE    (MISO_OE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Compare process: output invariants every cycle, frame results on each pulse.
    always @(negedge clk) begin
        if (sreset) begin
            prev_rx_valid = 1'b0;
        end else begin
            check("oe_eq_busy", 32'(MISO_OE), 32'(busy));
            if (!busy) check("miso_idle_low", 32'(MISO), 32'd0);
            if (rx_valid) begin
                check("rx_pulse_width", 32'(prev_rx_valid), 32'd0);
                rx_count++;
                last_rx_data  = rx_data;
                last_rx_nbits = int'(rx_nbits);
                last_rx_ovf   = rx_overrun;
                if (exp_rx_q.size() == 0) begin
                    check("rx_unexpected", 32'(rx_valid), 32'd0);
                end else begin
                    e_rx = exp_rx_q.pop_front();
                    check("rx_data", 32'(rx_data), 32'(e_rx.data));
                    check("rx_nbits", 32'(rx_nbits), 32'(e_rx.nbits));
                    check("rx_overrun", 32'(rx_overrun), 32'(e_rx.ovf));
                end
            end
            prev_rx_valid = rx_valid;
        end
    end

    task automatic load_tx(input logic [15:0] w);
        @(negedge clk);
        check("tx_ready_before_load", 32'(tx_ready), 32'd1);
        tx_valid = 1'b1;
        tx_data  = w;
        @(negedge clk);
        tx_valid = 1'b0;
        check("tx_ready_after_load", 32'(tx_ready), 32'd0);
        exp_tx_q.push_back(w);
    endtask

    task automatic offer_blocked(input logic [15:0] w);
        @(negedge clk);
        check("tx_ready_blocked", 32'(tx_ready), 32'd0);
        tx_valid = 1'b1;
        tx_data  = w;
        wait_clk(3);
        tx_valid = 1'b0;
        check("tx_ready_still_blocked", 32'(tx_ready), 32'd0);
    endtask

    // One SPI mode-0 frame of nbits; mosi holds the bits right-aligned, first bit highest.
    task automatic spi_xfer(input int nbits, input logic [31:0] mosi, input bit expect_rx,
                            input bit hs_on_fall, input logic [15:0] hs_word,
                            output logic [31:0] miso_got);
        logic [15:0] w;
        logic [31:0] exp_miso;
        rx_t         e;
        int          nb;
        if (exp_tx_q.size() > 0) w = exp_tx_q.pop_front();
        else if (hs_on_fall)     w = hs_word;
        else                     w = '0;
        exp_miso = '0;
        for (int i = 0; i < nbits; i++) begin
            exp_miso = {exp_miso[30:0], (i < N) ? w[N-1-i] : 1'b0};
        end
        if (expect_rx && nbits > 0) begin
            nb      = (nbits > N) ? N : nbits;
            e.data  = 16'((mosi >> (nbits - nb)) & ((32'd1 << nb) - 32'd1));
            e.nbits = nb;
            e.ovf   = (nbits > N);
            exp_rx_q.push_back(e);
        end
        miso_got = '0;
        @(negedge clk);
        SS_N = 1'b0;
        MOSI = (nbits > 0) ? mosi[nbits-1] : 1'b0;
        if (hs_on_fall) begin
            // Handshake lands on the clk edge where the SS_N fall is acted on.
            wait_clk(2);
            tx_valid = 1'b1;
            tx_data  = hs_word;
            @(negedge clk);
            tx_valid = 1'b0;
            check("tx_ready_after_start_hs", 32'(tx_ready), 32'd1);
            wait_clk(H - 3);
        end else begin
            wait_clk(H);
        end
        for (int i = 0; i < nbits; i++) begin
            miso_got = {miso_got[30:0], MISO};
            if (expect_rx && i == 0) check("busy_in_frame", 32'(busy), 32'd1);
            SCLK = 1'b1;
            wait_clk(H);
            SCLK = 1'b0;
            MOSI = (i + 1 < nbits) ? mosi[nbits-2-i] : 1'b0;
            wait_clk(H);
        end
        SS_N = 1'b1;
        wait_clk(H);
        if (expect_rx && nbits > 0) check("miso_stream", miso_got, exp_miso);
    endtask

    initial begin
        #1ms;
        $display("FAIL timeout: bench did not finish, tests=%0d", n_tests);
        $fatal(1, "timeout");
    end

    initial begin
        sreset   = 1'b1;
        tx_valid = 1'b0;
        tx_data  = '0;
        SCLK     = 1'b0;
        MOSI     = 1'b0;
        SS_N     = 1'b1;
        wait_clk(4);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_rx_nbits", 32'(rx_nbits), 32'd0);
        check("rst_rx_overrun", 32'(rx_overrun), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_miso", 32'(MISO), 32'd0);
        check("rst_miso_oe", 32'(MISO_OE), 32'd0);
        sreset = 1'b0;
        wait_clk(6);

        // Full 16-bit exchange with a preloaded word.
        load_tx(16'hA5C3);
        spi_xfer(16, 32'h1234, 1'b1, 1'b0, 16'h0, got);
        check("t1_miso_literal", got, 32'h0000A5C3);
        check("t1_rx_literal", 32'(last_rx_data), 32'h1234);
        check("t1_nbits_literal", 32'(last_rx_nbits), 32'd16);
        check("t1_ovf_literal", 32'(last_rx_ovf), 32'd0);
        check("t1_tx_ready", 32'(tx_ready), 32'd1);
        check("t1_rx_count", 32'(rx_count), 32'd1);

        // Short frame with nothing preloaded.
        spi_xfer(8, 32'h5A, 1'b1, 1'b0, 16'h0, got);
        check("t2_miso_literal", got, 32'h0);
        check("t2_rx_literal", 32'(last_rx_data), 32'h005A);
        check("t2_nbits_literal", 32'(last_rx_nbits), 32'd8);

        // Overrun: 20 clocks into a 16-bit target.
        load_tx(16'hFFFF);
        spi_xfer(20, 32'hABCDE, 1'b1, 1'b0, 16'h0, got);
        check("t3_miso_literal", got, 32'h000FFFF0);
        check("t3_rx_literal", 32'(last_rx_data), 32'hABCD);
        check("t3_nbits_literal", 32'(last_rx_nbits), 32'd16);
        check("t3_ovf_literal", 32'(last_rx_ovf), 32'd1);

        // Select pulse with no SCLK consumes the pending word, no rx pulse.
        load_tx(16'h1111);
        cnt_snap = rx_count;
        spi_xfer(0, 32'h0, 1'b1, 1'b0, 16'h0, got);
        check("t4_no_rx", 32'(rx_count), 32'(cnt_snap));
        check("t4_tx_ready", 32'(tx_ready), 32'd1);

        // Handshake on the frame-start edge, plus a second word held for the next frame.
        fork
            spi_xfer(16, 32'hC0DE, 1'b1, 1'b1, 16'h8001, got);
            begin
                wait_clk(40);
                load_tx(16'h3C3C);
            end
        join
        check("t5_miso_literal", got, 32'h00008001);
        check("t5_rx_literal", 32'(last_rx_data), 32'hC0DE);
        check("t5_pending_held", 32'(tx_ready), 32'd0);
        offer_blocked(16'hDEAD);
        spi_xfer(16, 32'h0F0F, 1'b1, 1'b0, 16'h0, got);
        check("t5_next_miso_literal", got, 32'h00003C3C);
        check("t5_tx_ready_after", 32'(tx_ready), 32'd1);

        // Reset in the middle of a frame with SS_N held low across release.
        cnt_snap = rx_count;
        fork
            spi_xfer(16, 32'hBEEF, 1'b0, 1'b0, 16'h0, got);
            begin
                wait_clk(75);
                sreset = 1'b1;
                wait_clk(4);
                sreset = 1'b0;
                exp_tx_q.delete();
            end
        join
        check("t6_no_partial_rx", 32'(rx_count), 32'(cnt_snap));
        spi_xfer(16, 32'h6E21, 1'b1, 1'b0, 16'h0, got);
        check("t6_rx_literal", 32'(last_rx_data), 32'h6E21);
        check("t6_rx_count", 32'(rx_count), 32'(cnt_snap + 1));

        wait_clk(10);
        check("rx_missing", 32'(exp_rx_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
